// File: rtl/onehot_encoder_arb.sv
// Registered request-vector selector: one-hot encode, fixed LSB priority or round-robin,
// with a single-entry backpressured result register and a sticky multi-hot error flag.
module onehot_encoder_arb #(
  parameter int unsigned C_WIDTH = 40,
  parameter int unsigned MODE    = 2,
  localparam int unsigned IDX_W  = (C_WIDTH == 1) ? 1 : $clog2(C_WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [C_WIDTH-1:0] req,
  output logic               req_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   int_out,
  output logic [C_WIDTH-1:0] grant_onehot,
  output logic               multi_hot_err,
  input  logic               err_clr
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_WIDTH - 1);

  logic               out_valid_q, out_valid_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [C_WIDTH-1:0] grant_q, grant_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic               accept;
  logic               load;
  logic [C_WIDTH-1:0] hi_mask;
  logic [C_WIDTH-1:0] masked_req;
  logic [IDX_W-1:0]   or_idx;
  logic               seen_one;
  logic               multi_hot;
  logic [IDX_W-1:0]   sel_idx;
  logic [C_WIDTH-1:0] sel_grant;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [C_WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = int'(C_WIDTH) - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Index selection for the configured mode; round-robin searches above ptr first, then wraps.
  always_comb begin
    hi_mask   = '0;
    or_idx    = '0;
    seen_one  = 1'b0;
    multi_hot = 1'b0;
    for (int i = 0; i < int'(C_WIDTH); i++) begin
      hi_mask[i] = (IDX_W'(i) > ptr_q);
      if (req[i]) begin
        or_idx    = or_idx | IDX_W'(i);
        multi_hot = multi_hot | seen_one;
        seen_one  = 1'b1;
      end
    end
    masked_req = req & hi_mask;
    case (MODE)
      0:       sel_idx = or_idx;
      1:       sel_idx = lowest_set(req);
      default: sel_idx = ((ptr_q != LAST_IDX) && (|masked_req)) ? lowest_set(masked_req)
                                                                : lowest_set(req);
    endcase
    // An OR-merged index beyond the vector decodes to no grant bit.
    sel_grant = C_WIDTH'(1) << sel_idx;
  end

  assign req_ready = !out_valid_q || out_ready;
  assign accept    = req_valid && req_ready;
  assign load      = accept && (|req);

  always_comb begin
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    err_d       = err_q;
    if (load) begin
      out_valid_d = 1'b1;
      idx_d       = sel_idx;
      grant_d     = sel_grant;
      if (MODE == 2) ptr_d = sel_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (err_clr) err_d = 1'b0;
    if ((MODE == 0) && load && multi_hot) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      grant_q     <= '0;
      err_q       <= 1'b0;
      ptr_q       <= LAST_IDX;
    end else begin
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      grant_q     <= grant_d;
      err_q       <= err_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign int_out       = idx_q;
  assign grant_onehot  = grant_q;
  assign multi_hot_err = err_q;

`ifndef SYNTHESIS
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
    (out_valid_q && !out_ready) |=> ($stable(idx_q) && $stable(grant_q)));
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst)
    out_valid_q |-> ($onehot(grant_q) || ((MODE == 0) && (grant_q == '0))));
`endif

endmodule
